// File: rtl/dcm_rst_seq.sv
// Reset sequencer for N_DCM clock managers followed by the ADC ISERDES stage.
// Resets all DCMs, waits for a confirmed lock on every one, then pulses the ISERDES reset.
//
//  state       | meaning
//  ------------+------------------------------------------------------------
//  S_IDLE      | waiting for init; retry_cnt / rst_fail keep last values
//  S_DCM_RST   | rst_dcm asserted for RST_CYC cycles
//  S_LOCK_WAIT | waiting for lk_all on 2 consecutive cycles, LOCK_TMO limit
//  S_ISD_RST   | rst_iserdes asserted for ISD_CYC cycles, rst_end on last
//  S_FAIL      | lock never achieved within the retry budget; rst_fail set
module dcm_rst_seq #(
    parameter int N_DCM     = 2,
    parameter int RST_CYC   = 3,
    parameter int ISD_CYC   = 3,
    parameter int LOCK_TMO  = 1023,
    parameter int MAX_RETRY = 3,
    parameter int CNT_W     = 10,
    localparam int RTY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             init,
    input  logic [N_DCM-1:0] locked,
    output logic             rst_dcm,
    output logic             rst_iserdes,
    output logic             rst_run,
    output logic             rst_end,
    output logic             rst_fail,
    output logic [RTY_W-1:0] retry_cnt
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DCM_RST   = 3'd1;
    localparam logic [2:0] S_LOCK_WAIT = 3'd2;
    localparam logic [2:0] S_ISD_RST   = 3'd3;
    localparam logic [2:0] S_FAIL      = 3'd4;

    localparam logic [CNT_W-1:0] C_RST_LAST = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] C_ISD_LAST = CNT_W'(ISD_CYC - 1);
    localparam logic [CNT_W-1:0] C_TMO_LAST = CNT_W'(LOCK_TMO - 1);
    localparam logic [RTY_W-1:0] C_MAX_RTY  = RTY_W'(MAX_RETRY);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [N_DCM-1:0] r_lk_meta;
    logic [N_DCM-1:0] r_lk_sync;
    logic             r_lk_seen;
    logic [RTY_W-1:0] r_retry;
    logic             r_rst_dcm;
    logic             r_rst_isd;
    logic             r_rst_run;
    logic             r_rst_end;
    logic             r_rst_fail;

    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [RTY_W-1:0] w_retry_nxt;
    logic             w_fail_nxt;
    logic             w_lk_all;
    logic             w_retry_ok;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_lk_meta <= '0;
            r_lk_sync <= '0;
        end else begin
            r_lk_meta <= locked;
            r_lk_sync <= r_lk_meta;
        end
    end

    assign w_lk_all   = &r_lk_sync;
    assign w_retry_ok = (r_retry < C_MAX_RTY);

    always_comb begin
        w_state_nxt = r_state;
        w_retry_nxt = r_retry;
        w_fail_nxt  = r_rst_fail;
        case (r_state)
            S_IDLE, S_FAIL: begin
                if (init) begin
                    w_state_nxt = S_DCM_RST;
                    w_retry_nxt = '0;
                    w_fail_nxt  = 1'b0;
                end
            end
            S_DCM_RST: begin
                if (r_cnt == C_RST_LAST) begin
                    w_state_nxt = S_LOCK_WAIT;
                end
            end
            S_LOCK_WAIT: begin
                if (w_lk_all && r_lk_seen) begin
                    w_state_nxt = S_ISD_RST;
                end else if (r_cnt == C_TMO_LAST) begin
                    if (w_retry_ok) begin
                        w_state_nxt = S_DCM_RST;
                        w_retry_nxt = r_retry + RTY_W'(1);
                    end else begin
                        w_state_nxt = S_FAIL;
                        w_fail_nxt  = 1'b1;
                    end
                end
            end
            S_ISD_RST: begin
                // rst_end is already on the wire in the last cycle, so that cycle always completes
                if (r_cnt == C_ISD_LAST) begin
                    w_state_nxt = S_IDLE;
                end else if (!w_lk_all) begin
                    if (w_retry_ok) begin
                        w_state_nxt = S_DCM_RST;
                        w_retry_nxt = r_retry + RTY_W'(1);
                    end else begin
                        w_state_nxt = S_FAIL;
                        w_fail_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_retry_nxt = '0;
                w_fail_nxt  = 1'b0;
            end
        endcase
    end

    // Counter restarts on every state change and saturates at all-ones.
    assign w_cnt_nxt = (w_state_nxt != r_state) ? '0 :
                       (&r_cnt)                 ? r_cnt :
                                                  r_cnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_lk_seen  <= 1'b0;
            r_retry    <= '0;
            r_rst_dcm  <= 1'b0;
            r_rst_isd  <= 1'b0;
            r_rst_run  <= 1'b0;
            r_rst_end  <= 1'b0;
            r_rst_fail <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_lk_seen  <= (r_state == S_LOCK_WAIT) && (w_state_nxt == S_LOCK_WAIT) && w_lk_all;
            r_retry    <= w_retry_nxt;
            r_rst_dcm  <= (w_state_nxt == S_DCM_RST);
            r_rst_isd  <= (w_state_nxt == S_ISD_RST);
            r_rst_run  <= (w_state_nxt == S_DCM_RST) || (w_state_nxt == S_LOCK_WAIT) ||
                          (w_state_nxt == S_ISD_RST);
            r_rst_end  <= (w_state_nxt == S_ISD_RST) && (w_cnt_nxt == C_ISD_LAST);
            r_rst_fail <= w_fail_nxt;
        end
    end

    assign rst_dcm     = r_rst_dcm;
    assign rst_iserdes = r_rst_isd;
    assign rst_run     = r_rst_run;
    assign rst_end     = r_rst_end;
    assign rst_fail    = r_rst_fail;
    assign retry_cnt   = r_retry;

endmodule
